// File: rtl/ex_muldiv_unit.sv
// Iterative SPARC V8 multiply/divide unit for the execute stage.
// Holds ID/EX via ex_ready while a UMUL/SMUL/UDIV/SDIV (and cc forms) runs.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_valid,
    input  logic             kill,
    input  logic [5:0]       op3,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic             i,
    input  logic [12:0]      imm13,
    input  logic [WIDTH-1:0] Y_in,
    output logic             ex_ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] Y_out,
    output logic             Y_write,
    output logic [3:0]       icc_out,
    output logic             icc_write,
    output logic             div_zero
);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    localparam int CW = $clog2(ITERS);

    state_t state, state_nxt;

    logic [5:0]         op3_p0;
    logic [WIDTH-1:0]   a_p0, b_p0, y_p0;
    logic [2*WIDTH-1:0] acc_p1;
    logic [WIDTH-1:0]   dsr_p1;
    logic [CW-1:0]      cnt_p1;
    logic               neg_p1, ovf_p1, dz_p1;

    logic is_sgn, is_div, is_cc;
    assign is_sgn = op3_p0[0];
    assign is_cc  = op3_p0[4];
    assign is_div = !op3_p0[5] && (op3_p0[3:1] == 3'b111);

    // Saturating quotient fix-up; returns {overflow, result}.
    function automatic logic [WIDTH:0] sat_quot(input logic [WIDTH-1:0] q, input logic sgn,
                                                input logic neg, input logic ovf);
        logic [WIDTH-1:0] smax, smin;
        logic [WIDTH:0]   r;
        smax = {1'b0, {(WIDTH-1){1'b1}}};
        smin = {1'b1, {(WIDTH-1){1'b0}}};
        if (!sgn)
            r = ovf ? {1'b1, {WIDTH{1'b1}}} : {1'b0, q};
        else if (!neg)
            r = (ovf || q[WIDTH-1]) ? {1'b1, smax} : {1'b0, q};
        else
            r = (ovf || q > smin) ? {1'b1, smin} : {1'b0, -q};
        return r;
    endfunction

    logic [2*WIDTH-1:0] dvd, dvd_mag;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg_prep, ovf_prep, dz_prep;

    always_comb begin
        dvd      = {y_p0, a_p0};
        dvd_mag  = (is_sgn && dvd[2*WIDTH-1]) ? -dvd : dvd;
        a_mag    = (is_sgn && a_p0[WIDTH-1]) ? -a_p0 : a_p0;
        b_mag    = (is_sgn && b_p0[WIDTH-1]) ? -b_p0 : b_p0;
        neg_prep = is_sgn && ((is_div ? dvd[2*WIDTH-1] : a_p0[WIDTH-1]) ^ b_p0[WIDTH-1]);
        dz_prep  = is_div && (b_p0 == '0);
        ovf_prep = is_div && (dvd_mag[2*WIDTH-1:WIDTH] >= b_mag);
    end

    // Multiply keeps the multiplier in the low half and shifts right;
    // divide keeps the partial remainder in the high half and shifts left.
    logic [WIDTH:0]     mul_sum, div_up;
    logic [WIDTH-1:0]   div_dif;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_nxt;

    always_comb begin
        mul_sum = {1'b0, acc_p1[2*WIDTH-1:WIDTH]} + (acc_p1[0] ? {1'b0, dsr_p1} : '0);
        div_up  = acc_p1[2*WIDTH-1:WIDTH-1];
        div_ge  = div_up >= {1'b0, dsr_p1};
        div_dif = div_up[WIDTH-1:0] - dsr_p1;
        if (is_div)
            acc_nxt = {(div_ge ? div_dif : div_up[WIDTH-1:0]), acc_p1[WIDTH-2:0], div_ge};
        else
            acc_nxt = {mul_sum, acc_p1[WIDTH-1:1]};
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     quot;
    logic [WIDTH-1:0]   fix_res;
    logic [3:0]         fix_icc;

    always_comb begin
        prod    = neg_p1 ? -acc_p1 : acc_p1;
        quot    = sat_quot(acc_p1[WIDTH-1:0], is_sgn, neg_p1, ovf_p1);
        fix_res = is_div ? quot[WIDTH-1:0] : prod[WIDTH-1:0];
        fix_icc = {fix_res[WIDTH-1], fix_res == '0, is_div && quot[WIDTH], 1'b0};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (md_valid) state_nxt = PREP;
            PREP: begin
                if (dz_prep)       state_nxt = DONE;
                else if (ovf_prep) state_nxt = FIX;
                else               state_nxt = ITER;
            end
            ITER: if (cnt_p1 == CW'(ITERS - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    assign ex_ready  = (state == IDLE && !md_valid) || (state == DONE);
    assign done      = (state == DONE);
    assign Y_write   = done && !is_div;
    assign icc_write = done && is_cc && !dz_p1;
    assign div_zero  = done && dz_p1;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Stage p0: operand capture; stage p1: magnitude setup and iteration.
    always_ff @(posedge clk) begin
        if (state == IDLE && md_valid) begin
            op3_p0 <= op3;
            a_p0   <= valA;
            b_p0   <= i ? {{(WIDTH-13){imm13[12]}}, imm13} : valB;
            y_p0   <= Y_in;
        end
        if (state == PREP) begin
            acc_p1 <= is_div ? dvd_mag : {{WIDTH{1'b0}}, b_mag};
            dsr_p1 <= is_div ? b_mag : a_mag;
            neg_p1 <= neg_prep;
            ovf_p1 <= ovf_prep;
            dz_p1  <= dz_prep;
            cnt_p1 <= '0;
        end
        if (state == ITER) begin
            acc_p1 <= acc_nxt;
            cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result  <= '0;
            Y_out   <= '0;
            icc_out <= '0;
        end else if (!kill) begin
            if (state == PREP && dz_prep)
                result <= '0;
            if (state == FIX) begin
                result  <= fix_res;
                icc_out <= fix_icc;
                if (!is_div) Y_out <= prod[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table through a scoreboard,
// plus kill and reset abort sequences.
module tb_ex_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, md_valid, kill, i;
    logic [5:0]   op3;
    logic [W-1:0] valA, valB, Y_in;
    logic [12:0]  imm13;
    logic         ex_ready, done, Y_write, icc_write, div_zero;
    logic [W-1:0] result, Y_out;
    logic [3:0]   icc_out;

    ex_muldiv_unit #(.WIDTH(W), .ITERS(W)) dut (
        .clk(clk), .reset(reset), .md_valid(md_valid), .kill(kill), .op3(op3),
        .valA(valA), .valB(valB), .i(i), .imm13(imm13), .Y_in(Y_in),
        .ex_ready(ex_ready), .done(done), .result(result), .Y_out(Y_out),
        .Y_write(Y_write), .icc_out(icc_out), .icc_write(icc_write), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op3;
        logic [31:0] a, b, y;
        logic        i;
        logic [12:0] imm;
        logic [31:0] res, yo;
        logic        ywr;
        logic [3:0]  icc;
        logic        iccwr, dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic [5:0] o, logic [31:0] a, logic [31:0] b, logic ii,
                                logic [12:0] imm, logic [31:0] y, logic [31:0] res,
                                logic [31:0] yo, logic ywr, logic [3:0] icc, logic iccwr,
                                logic dz, int lat);
        vec_t v;
        v.op3 = o; v.a = a; v.b = b; v.i = ii; v.imm = imm; v.y = y;
        v.res = res; v.yo = yo; v.ywr = ywr; v.icc = icc; v.iccwr = iccwr;
        v.dz = dz; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v, input bit push);
        op3 = v.op3; valA = v.a; valB = v.b; i = v.i; imm13 = v.imm; Y_in = v.y;
        md_valid = 1'b1;
        if (push) sb.push_back(v);
        #1;
    endtask

    // Called during cycle 0 of an op; returns sampled in the done cycle.
    task automatic wait_and_check();
        int   lat;
        bit   rdy_ok;
        vec_t e;
        lat = 0;
        rdy_ok = 1'b1;
        while (!done && lat < 60) begin
            if (ex_ready) rdy_ok = 1'b0;
            @(negedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        if (!done) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            chk("latency", 64'(lat), 64'(e.lat));
            chk("ready_low", 64'(rdy_ok), 64'd1);
            chk("ready_in_done", 64'(ex_ready), 64'd1);
            chk("result", 64'(result), 64'(e.res));
            chk("Y_write", 64'(Y_write), 64'(e.ywr));
            chk("icc_write", 64'(icc_write), 64'(e.iccwr));
            chk("div_zero", 64'(div_zero), 64'(e.dz));
            if (e.ywr)   chk("Y_out", 64'(Y_out), 64'(e.yo));
            if (e.iccwr) chk("icc", 64'(icc_out), 64'(e.icc));
        end
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (done) seen = 1'b1;
            @(negedge clk); #1;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        vec_t abort_op;
        reset = 1'b1; md_valid = 1'b0; kill = 1'b0; i = 1'b0;
        op3 = '0; valA = '0; valB = '0; imm13 = '0; Y_in = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_Y_out", 64'(Y_out), 64'd0);
        chk("rst_icc", 64'(icc_out), 64'd0);
        chk("rst_writes", 64'({Y_write, icc_write, div_zero}), 64'd0);
        chk("rst_ready", 64'(ex_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk); #1;

        //          op3    valA          valB          i  imm13     Y_in          result        Y_out         yw icc     iw dz lat
        vecs.push_back(mk(6'h0A, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 13'h0,    32'h0,        32'h00000001, 32'hFFFFFFFE, 1, 4'b0000, 0, 0, 35));
        vecs.push_back(mk(6'h1B, 32'hFFFFFFFD, 32'h12345678, 1, 13'h5,    32'h0,        32'hFFFFFFF1, 32'hFFFFFFFF, 1, 4'b1000, 1, 0, 35));
        vecs.push_back(mk(6'h0E, 32'h0,        32'h2,        0, 13'h0,    32'h1,        32'h80000000, 32'h0,        0, 4'b0000, 0, 0, 35));
        vecs.push_back(mk(6'h1E, 32'h0,        32'h2,        0, 13'h0,    32'h2,        32'hFFFFFFFF, 32'h0,        0, 4'b1010, 1, 0, 3));
        vecs.push_back(mk(6'h0F, 32'hFFFFFFF9, 32'h2,        0, 13'h0,    32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0,        0, 4'b0000, 0, 0, 35));
        vecs.push_back(mk(6'h1F, 32'h80000000, 32'h1,        0, 13'h0,    32'h0,        32'h7FFFFFFF, 32'h0,        0, 4'b0010, 1, 0, 35));
        vecs.push_back(mk(6'h1E, 32'h5,        32'h0,        0, 13'h0,    32'h0,        32'h0,        32'h0,        0, 4'b0000, 0, 1, 2));
        vecs.push_back(mk(6'h1A, 32'h0,        32'h12345,    0, 13'h0,    32'h0,        32'h0,        32'h0,        1, 4'b0100, 1, 0, 35));
        vecs.push_back(mk(6'h0B, 32'h7,        32'h0,        1, 13'h1FFF, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1, 4'b0000, 0, 0, 35));
        vecs.push_back(mk(6'h0E, 32'd100,      32'd7,        0, 13'h0,    32'h0,        32'd14,       32'h0,        0, 4'b0000, 0, 0, 35));
        vecs.push_back(mk(6'h1F, 32'h80000000, 32'hFFFFFFFF, 0, 13'h0,    32'h0,        32'h80000000, 32'h0,        0, 4'b1000, 1, 0, 35));
        vecs.push_back(mk(6'h1F, 32'h0,        32'h2,        0, 13'h0,    32'hFFFFFFFE, 32'h80000000, 32'h0,        0, 4'b1010, 1, 0, 3));
        vecs.push_back(mk(6'h1F, 32'h80000001, 32'hFFFFFFFF, 0, 13'h0,    32'h0,        32'h80000000, 32'h0,        0, 4'b1010, 1, 0, 35));

        drive(vecs[0], 1'b1);
        for (int k = 0; k < vecs.size(); k++) begin
            wait_and_check();
            if (k + 1 < vecs.size()) drive(vecs[k+1], 1'b1);
            else md_valid = 1'b0;
            @(negedge clk); #1;
            chk("done_pulse", 64'(done), 64'd0);
        end

        // Kill a UMUL at cycle 20: no done, outputs keep the last result.
        abort_op = mk(6'h0A, 32'h3, 32'h5, 0, 13'h0, 32'h0, 32'hF, 32'h0, 1, 4'b0, 0, 0, 35);
        drive(abort_op, 1'b0);
        repeat (20) begin @(negedge clk); #1; end
        kill = 1'b1; md_valid = 1'b0;
        @(negedge clk); #1;
        kill = 1'b0;
        chk("kill_ready", 64'(ex_ready), 64'd1);
        watch_no_done("kill_no_done", 40);
        chk("kill_result_held", 64'(result), 64'h80000000);
        chk("kill_icc_held", 64'(icc_out), 64'(4'b1010));

        // Reset a UMUL at cycle 10: outputs cleared, no done.
        drive(abort_op, 1'b0);
        repeat (10) begin @(negedge clk); #1; end
        reset = 1'b1; md_valid = 1'b0;
        @(negedge clk); #1;
        reset = 1'b0;
        chk("rst2_result", 64'(result), 64'd0);
        chk("rst2_Y_out", 64'(Y_out), 64'd0);
        chk("rst2_icc", 64'(icc_out), 64'd0);
        chk("rst2_ready", 64'(ex_ready), 64'd1);
        watch_no_done("rst2_no_done", 40);

        // A following SMUL completes normally.
        drive(mk(6'h0B, 32'hFFFFFFFE, 32'h3, 0, 13'h0, 32'h0, 32'hFFFFFFFA, 32'hFFFFFFFF,
                 1, 4'b0000, 0, 0, 35), 1'b1);
        wait_and_check();
        md_valid = 1'b0;
        @(negedge clk); #1;
        chk("final_done_pulse", 64'(done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
